// File: rtl/acc_datapath_dft.sv
// acc_datapath_dft: WIDTH-generic accumulator with op-coded ALU, shift-add
// multiplier (Busy handshake), registered carry/overflow flags and a full
// scan chain scan_in -> V -> C -> AC[WIDTH-1] ... AC[0] -> scan_out.
// Optional build macro: SAT_ARITH_EN (signed saturation on ADD/SUB).
module acc_datapath_dft #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] ABus,
    input  logic [2:0]       Op,
    input  logic             LoadAC,
    input  logic             scan_en,
    input  logic             scan_in,
    output logic [WIDTH-1:0] OutBus,
    output logic [WIDTH-1:0] HiBus,
    output logic             CarryFlag,
    output logic             OvfFlag,
    output logic             ZeroFlag,
    output logic             Busy,
    output logic             scan_out
);

    localparam int unsigned CW = $clog2(WIDTH + 1);

    localparam logic [2:0] OP_LOAD = 3'b000;
    localparam logic [2:0] OP_ADD  = 3'b001;
    localparam logic [2:0] OP_SUB  = 3'b010;
    localparam logic [2:0] OP_AND  = 3'b011;
    localparam logic [2:0] OP_OR   = 3'b100;
    localparam logic [2:0] OP_XOR  = 3'b101;
    localparam logic [2:0] OP_SHR  = 3'b110;
    localparam logic [2:0] OP_MUL  = 3'b111;

`ifdef SAT_ARITH_EN
    localparam logic [WIDTH-1:0] SAT_MAX = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0] SAT_MIN = {1'b1, {(WIDTH-1){1'b0}}};
`endif

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_MUL  = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] ac_q, ac_d;
    logic [WIDTH-1:0] mq_q, mq_d;
    logic [WIDTH-1:0] mcand_q, mcand_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             c_q, c_d;
    logic             v_q, v_d;

    logic             accept;
    logic             last_iter;
    logic [WIDTH:0]   add_full;
    logic [WIDTH:0]   sub_full;
    logic             add_ovf;
    logic             sub_ovf;
    logic [WIDTH:0]   mul_sum;
    logic [WIDTH-1:0] mul_mq;
    logic [WIDTH-1:0] mul_ac;

    // Operation acceptance, ALU results and one multiply iteration step
    always_comb begin
        accept    = LoadAC && (state_q == ST_IDLE) && !scan_en;
        last_iter = (cnt_q == CW'(WIDTH - 1));
        add_full  = {1'b0, ac_q} + {1'b0, ABus};
        sub_full  = {1'b0, ac_q} - {1'b0, ABus};
        add_ovf   = (ac_q[WIDTH-1] == ABus[WIDTH-1]) && (add_full[WIDTH-1] != ac_q[WIDTH-1]);
        sub_ovf   = (ac_q[WIDTH-1] != ABus[WIDTH-1]) && (sub_full[WIDTH-1] != ac_q[WIDTH-1]);
        mul_sum   = ac_q[0] ? ({1'b0, mq_q} + {1'b0, mcand_q}) : {1'b0, mq_q};
        mul_mq    = mul_sum[WIDTH:1];
        mul_ac    = {mul_sum[0], ac_q[WIDTH-1:1]};
    end

    // FSM state register
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state: scan aborts a multiply, last iteration returns to idle
    always_comb begin
        state_d = state_q;
        if (scan_en) begin
            state_d = ST_IDLE;
        end else if (state_q == ST_MUL) begin
            if (last_iter) begin
                state_d = ST_IDLE;
            end
        end else if (accept && (Op == OP_MUL)) begin
            state_d = ST_MUL;
        end
    end

    // Datapath registers
    always_ff @(posedge clock) begin
        if (reset) begin
            ac_q    <= '0;
            mq_q    <= '0;
            mcand_q <= '0;
            cnt_q   <= '0;
            c_q     <= 1'b0;
            v_q     <= 1'b0;
        end else begin
            ac_q    <= ac_d;
            mq_q    <= mq_d;
            mcand_q <= mcand_d;
            cnt_q   <= cnt_d;
            c_q     <= c_d;
            v_q     <= v_d;
        end
    end

    // Datapath next values: scan shift > multiply iteration > accepted op > hold
    always_comb begin
        ac_d    = ac_q;
        mq_d    = mq_q;
        mcand_d = mcand_q;
        cnt_d   = cnt_q;
        c_d     = c_q;
        v_d     = v_q;
        if (scan_en) begin
            v_d  = scan_in;
            c_d  = v_q;
            ac_d = {c_q, ac_q[WIDTH-1:1]};
        end else if (state_q == ST_MUL) begin
            ac_d  = mul_ac;
            mq_d  = mul_mq;
            cnt_d = cnt_q + CW'(1);
            if (last_iter) begin
                c_d = (mul_mq != '0);
                v_d = 1'b0;
            end
        end else if (accept) begin
            case (Op)
                OP_LOAD: ac_d = ABus;
                OP_ADD: begin
                    c_d  = add_full[WIDTH];
                    v_d  = add_ovf;
                    ac_d = add_full[WIDTH-1:0];
`ifdef SAT_ARITH_EN
                    if (add_ovf) begin
                        ac_d = ac_q[WIDTH-1] ? SAT_MIN : SAT_MAX;
                    end
`endif
                end
                OP_SUB: begin
                    c_d  = sub_full[WIDTH];
                    v_d  = sub_ovf;
                    ac_d = sub_full[WIDTH-1:0];
`ifdef SAT_ARITH_EN
                    if (sub_ovf) begin
                        ac_d = ac_q[WIDTH-1] ? SAT_MIN : SAT_MAX;
                    end
`endif
                end
                OP_AND: begin
                    ac_d = ac_q & ABus;
                    c_d  = 1'b0;
                    v_d  = 1'b0;
                end
                OP_OR: begin
                    ac_d = ac_q | ABus;
                    c_d  = 1'b0;
                    v_d  = 1'b0;
                end
                OP_XOR: begin
                    ac_d = ac_q ^ ABus;
                    c_d  = 1'b0;
                    v_d  = 1'b0;
                end
                OP_SHR: begin
                    ac_d = {1'b0, ac_q[WIDTH-1:1]};
                    c_d  = ac_q[0];
                    v_d  = 1'b0;
                end
                OP_MUL: begin
                    mcand_d = ABus;
                    mq_d    = '0;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    // Outputs straight from state; ZeroFlag decoded from AC
    always_comb begin
        OutBus    = ac_q;
        HiBus     = mq_q;
        CarryFlag = c_q;
        OvfFlag   = v_q;
        ZeroFlag  = (ac_q == '0);
        Busy      = (state_q == ST_MUL);
        scan_out  = ac_q[0];
    end

endmodule

// File: tb/tb_acc_datapath_dft.sv
// Self-checking bench for acc_datapath_dft (WIDTH=8). A spec-level model
// pushes expected state to a scoreboard; each test pops and compares it.
module tb_acc_datapath_dft;

    localparam int unsigned W  = 8;
    localparam int unsigned OW = 2 * W + 4;

    logic         clock;
    logic         reset;
    logic [W-1:0] ABus;
    logic [2:0]   Op;
    logic         LoadAC;
    logic         scan_en;
    logic         scan_in;
    logic [W-1:0] OutBus;
    logic [W-1:0] HiBus;
    logic         CarryFlag;
    logic         OvfFlag;
    logic         ZeroFlag;
    logic         Busy;
    logic         scan_out;

    acc_datapath_dft #(.WIDTH(W)) dut (
        .clock    (clock),
        .reset    (reset),
        .ABus     (ABus),
        .Op       (Op),
        .LoadAC   (LoadAC),
        .scan_en  (scan_en),
        .scan_in  (scan_in),
        .OutBus   (OutBus),
        .HiBus    (HiBus),
        .CarryFlag(CarryFlag),
        .OvfFlag  (OvfFlag),
        .ZeroFlag (ZeroFlag),
        .Busy     (Busy),
        .scan_out (scan_out)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Observed vector layout: {OutBus, HiBus, C, V, Z, Busy}
    logic [OW-1:0] obs;
    assign obs = {OutBus, HiBus, CarryFlag, OvfFlag, ZeroFlag, Busy};

    typedef struct {
        string         name;
        logic [OW-1:0] val;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    logic [W-1:0] m_ac, m_mq;
    logic         m_c, m_v;

    task automatic cycle();
        @(posedge clock);
        #1;
    endtask

    task automatic push_exp(input string nm, input logic busy);
        exp_t e;
        e.name = nm;
        e.val  = {m_ac, m_mq, m_c, m_v, (m_ac == '0), busy};
        sb.push_back(e);
    endtask

    task automatic drive_op(input logic [2:0] op, input logic [W-1:0] a);
        Op     = op;
        ABus   = a;
        LoadAC = 1'b1;
        cycle();
        LoadAC = 1'b0;
    endtask

    task automatic model_reset();
        m_ac = '0;
        m_mq = '0;
        m_c  = 1'b0;
        m_v  = 1'b0;
    endtask

    // Reference ALU in integer arithmetic
    task automatic model_op(input logic [2:0] op, input logic [W-1:0] a);
        int s;
        int lim_hi;
        int lim_lo;
        logic ovf;
        lim_hi = (2 ** (W - 1)) - 1;
        lim_lo = -(2 ** (W - 1));
        case (op)
            3'd0: m_ac = a;
            3'd1, 3'd2: begin
                if (op == 3'd1) begin
                    s   = int'($signed(m_ac)) + int'($signed(a));
                    m_c = (int'(m_ac) + int'(a)) > (2 ** W - 1);
                end else begin
                    s   = int'($signed(m_ac)) - int'($signed(a));
                    m_c = m_ac < a;
                end
                ovf = (s > lim_hi) || (s < lim_lo);
                m_v = ovf;
`ifdef SAT_ARITH_EN
                if (ovf) m_ac = (s > lim_hi) ? W'(lim_hi) : W'(lim_lo);
                else     m_ac = W'(s);
`else
                m_ac = W'(s);
`endif
            end
            3'd3: begin m_ac = m_ac & a; m_c = 1'b0; m_v = 1'b0; end
            3'd4: begin m_ac = m_ac | a; m_c = 1'b0; m_v = 1'b0; end
            3'd5: begin m_ac = m_ac ^ a; m_c = 1'b0; m_v = 1'b0; end
            3'd6: begin m_c = m_ac[0]; m_ac = m_ac >> 1; m_v = 1'b0; end
            default: ;
        endcase
    endtask

    // Closed form after k shift-add iterations of A*B
    task automatic model_mul_partial(input logic [W-1:0] a, input logic [W-1:0] b, input int k);
        int p;
        int mask;
        mask = (1 << k) - 1;
        p    = int'(b) * (int'(a) & mask);
        m_mq = W'(p >> k);
        m_ac = W'(((p & mask) << (W - k)) | (int'(a) >> k));
    endtask

    task automatic model_scan(input logic si);
        logic [W-1:0] nac;
        nac  = {m_c, m_ac[W-1:1]};
        m_c  = m_v;
        m_v  = si;
        m_ac = nac;
    endtask

    task automatic test_reset();
        exp_t e;
        reset = 1'b1;
        cycle();
        reset = 1'b0;
        model_reset();
        push_exp("reset", 1'b0);
        e = sb.pop_front();
        n_checks++;
        if (obs !== e.val) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", e.name, obs, e.val);
        end
        n_checks++;
        if (scan_out !== 1'b0) begin
            n_fail++;
            $display("FAIL reset scan_out: got %b expected 0", scan_out);
        end
    endtask

    task automatic test_arith();
        exp_t e;
        logic [2:0]   ops [6] = '{3'd0, 3'd1, 3'd0, 3'd1, 3'd2, 3'd2};
        logic [W-1:0] as  [6] = '{8'h7F, 8'h01, 8'hFF, 8'h80, 8'h80, 8'h01};
        for (int i = 0; i < 6; i++) begin
            model_op(ops[i], as[i]);
            push_exp($sformatf("arith op%0d a=%h", ops[i], as[i]), 1'b0);
            drive_op(ops[i], as[i]);
            e = sb.pop_front();
            n_checks++;
            if (obs !== e.val) begin
                n_fail++;
                $display("FAIL %s: got %h expected %h", e.name, obs, e.val);
            end
        end
    endtask

    task automatic test_logic();
        exp_t e;
        logic [2:0]   ops [8] = '{3'd0, 3'd2, 3'd6, 3'd5, 3'd0, 3'd3, 3'd4, 3'd6};
        logic [W-1:0] as  [8] = '{8'h05, 8'h07, 8'h55, 8'h7F, 8'hC3, 8'h0F, 8'h30, 8'h00};
        for (int i = 0; i < 8; i++) begin
            model_op(ops[i], as[i]);
            push_exp($sformatf("logic op%0d a=%h", ops[i], as[i]), 1'b0);
            drive_op(ops[i], as[i]);
            e = sb.pop_front();
            n_checks++;
            if (obs !== e.val) begin
                n_fail++;
                $display("FAIL %s: got %h expected %h", e.name, obs, e.val);
            end
        end
    endtask

    task automatic test_mul();
        exp_t e;
        logic [W-1:0] ma [2] = '{8'h0F, 8'h20};
        logic [W-1:0] mb [2] = '{8'h11, 8'h13};
        int p;
        int busy_cnt;
        int guard;
        for (int i = 0; i < 2; i++) begin
            model_op(3'd0, ma[i]);
            push_exp($sformatf("mul load %h", ma[i]), 1'b0);
            drive_op(3'd0, ma[i]);
            e = sb.pop_front();
            n_checks++;
            if (obs !== e.val) begin
                n_fail++;
                $display("FAIL %s: got %h expected %h", e.name, obs, e.val);
            end
            p    = int'(ma[i]) * int'(mb[i]);
            m_ac = W'(p);
            m_mq = W'(p >> W);
            m_c  = (m_mq != '0);
            m_v  = 1'b0;
            push_exp($sformatf("mul %h*%h", ma[i], mb[i]), 1'b0);
            drive_op(3'd7, mb[i]);
            busy_cnt = 0;
            guard    = 0;
            while (Busy === 1'b1 && guard < 4 * W) begin
                busy_cnt++;
                if (busy_cnt == 3) begin
                    Op     = 3'd0;
                    ABus   = W'(8'hAA);
                    LoadAC = 1'b1;
                end
                cycle();
                LoadAC = 1'b0;
                guard++;
            end
            n_checks++;
            if (busy_cnt != W) begin
                n_fail++;
                $display("FAIL mul busy cycles: got %0d expected %0d", busy_cnt, W);
            end
            e = sb.pop_front();
            n_checks++;
            if (obs !== e.val) begin
                n_fail++;
                $display("FAIL %s: got %h expected %h", e.name, obs, e.val);
            end
        end
    endtask

    task automatic test_scan();
        exp_t e;
        logic bits [10] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
        logic so   [10] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        model_op(3'd0, 8'h05);
        drive_op(3'd0, 8'h05);
        model_op(3'd2, 8'h07);
        push_exp("scan setup", 1'b0);
        drive_op(3'd2, 8'h07);
        e = sb.pop_front();
        n_checks++;
        if (obs !== e.val) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", e.name, obs, e.val);
        end
        for (int i = 0; i < 10; i++) begin
            n_checks++;
            if (scan_out !== so[i]) begin
                n_fail++;
                $display("FAIL scan_out[%0d]: got %b expected %b", i, scan_out, so[i]);
            end
            scan_en = 1'b1;
            scan_in = bits[i];
            model_scan(bits[i]);
            cycle();
        end
        scan_en = 1'b0;
        push_exp("scan final", 1'b0);
        e = sb.pop_front();
        n_checks++;
        if (obs !== e.val) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", e.name, obs, e.val);
        end
    endtask

    task automatic test_abort();
        exp_t e;
        logic [W-1:0] ma [2] = '{8'h20, 8'hB7};
        logic [W-1:0] mb [2] = '{8'h13, 8'h5D};
        int           ks [2] = '{3, 5};
        for (int i = 0; i < 2; i++) begin
            model_op(3'd0, ma[i]);
            drive_op(3'd0, ma[i]);
            m_mq = '0;
            drive_op(3'd7, mb[i]);
            for (int j = 0; j < ks[i]; j++) cycle();
            model_mul_partial(ma[i], mb[i], ks[i]);
            push_exp($sformatf("mul partial k=%0d", ks[i]), 1'b1);
            e = sb.pop_front();
            n_checks++;
            if (obs !== e.val) begin
                n_fail++;
                $display("FAIL %s: got %h expected %h", e.name, obs, e.val);
            end
            if (i == 0) begin
                scan_en = 1'b1;
                scan_in = 1'b0;
                model_scan(1'b0);
                cycle();
                scan_en = 1'b0;
                push_exp("scan abort", 1'b0);
            end else begin
                reset = 1'b1;
                cycle();
                reset = 1'b0;
                model_reset();
                push_exp("reset abort", 1'b0);
            end
            e = sb.pop_front();
            n_checks++;
            if (obs !== e.val) begin
                n_fail++;
                $display("FAIL %s: got %h expected %h", e.name, obs, e.val);
            end
            cycle();
            push_exp("idle after abort", 1'b0);
            e = sb.pop_front();
            n_checks++;
            if (obs !== e.val) begin
                n_fail++;
                $display("FAIL %s: got %h expected %h", e.name, obs, e.val);
            end
        end
    endtask

    initial begin
        reset   = 1'b1;
        ABus    = '0;
        Op      = 3'd0;
        LoadAC  = 1'b0;
        scan_en = 1'b0;
        scan_in = 1'b0;
        test_reset();
        test_arith();
        test_logic();
        test_mul();
        test_scan();
        test_abort();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
